intra_layer_block_executor: RTL and testbench
=============================================

Name: intra_layer_block_executor

Overview:
Consumer end of the intra-layer block scheduler interface. Latches the current block descriptor (block0/block1 start and length, block type) and issues one element command per index to the compute engine over a valid/ready stream. It counts engine completions and returns a one-cycle block_finish_valid_o pulse to the scheduler once every element of the block has completed.

Parameters:
ADDR_W, 32, width of start/length/index fields
MAX_OUTSTANDING, 4, maximum issued-but-uncompleted commands (1..15)

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
block0_start_i  input  ADDR_W  first index of sub-block 0
block0_length_i  input  ADDR_W  element count of sub-block 0
block1_start_i  input  ADDR_W  first index of sub-block 1
block1_length_i  input  ADDR_W  element count of sub-block 1
block_type_i  input  2  00 none, 01 forward, 10 backward, 11 fused
block_finish_valid_o  output  1  one-cycle pulse: current block fully completed
cmd_valid_o  output  1  element command valid
cmd_ready_i  input  1  engine accepts command
cmd_index_o  output  ADDR_W  element index
cmd_sel_o  output  1  0 = sub-block 0, 1 = sub-block 1
cmd_type_o  output  2  latched block type
cmd_last_o  output  1  final command of the block
rsp_valid_i  input  1  one element completed (one per cycle max)
busy_o  output  1  block latched and not yet finished

Behaviour:
- Clock clk_i; reset rst_ni is asynchronous and active-low. All state and outputs clear on reset: FSM=IDLE, all outputs 0, counters 0.
- FSM states: IDLE, ISSUE, DRAIN, DONE, HOLD.
- IDLE: if block_type_i != 00, latch all descriptor inputs into internal registers in that cycle and go to ISSUE. busy_o=1 from the next cycle. The latched copy is used thereafter; input changes mid-block are ignored.
- ISSUE: walk sub-block 0 indices start0 .. start0+len0-1, then sub-block 1 indices start1 .. start1+len1-1.
  - A sub-block with length 0 is skipped with no bubble cycle.
  - Index arithmetic is modulo 2^ADDR_W, so start+offset wraps.
- cmd_valid_o=1 in ISSUE only while outstanding < MAX_OUTSTANDING.
- Command handshake: a command transfers when cmd_valid_o && cmd_ready_i. Once valid is raised, cmd_index_o, cmd_sel_o, cmd_type_o and cmd_last_o hold stable until the transfer.
- cmd_last_o=1 on the final element of the block, which is the last element of sub-block 1, or of sub-block 0 if len1 == 0.
- Outstanding counter: +1 on a command transfer, -1 on rsp_valid_i. Both in the same cycle leave it unchanged. rsp_valid_i with outstanding == 0 is ignored and does not underflow.
- ISSUE -> DRAIN on the transfer of the last command. If len0 == len1 == 0, go directly IDLE-latch -> ISSUE -> DONE with no commands issued.
- DRAIN -> DONE in the cycle outstanding reaches 0.
- DONE: block_finish_valid_o=1 for exactly one cycle, then HOLD. busy_o deasserts the cycle after DONE.
- HOLD: one cycle, no latch, so the scheduler can update its descriptor on the finish edge. Then IDLE.
- Finish-to-next-latch latency: the pulse in cycle N, the descriptor sampled in cycle N+2 at the earliest.
- Minimum block latency with cmd_ready_i=1 and single-cycle responses: total_len + 3 cycles from latch to finish pulse.
- Asynchronous reset mid-block drops all outstanding state. No finish pulse is generated for the aborted block.

Test Plan:
1. Reset then forward block: type 01, start0=0, len0=7, start1=7, len1=3, ready=1, rsp one cycle after each transfer -> indices 0..9 in order, sel=0 for 0..6 and 1 for 7..9, cmd_last_o on index 9, exactly one finish pulse, busy_o low afterwards.
2. Backpressure: same descriptor, cmd_ready_i toggling 1/0, responses withheld -> at most 4 commands in flight, then valid drops, indices held stable while ready=0. Releasing rsp resumes issue.
3. Zero lengths: type 10, len0=0, start1=0, len1=4 -> four commands sel=1 indices 0..3, last on index 3. Then type 01 with len0=len1=0 -> no commands, finish pulse 2 cycles after latch.
4. Back-to-back blocks: after the finish pulse, the scheduler updates to the backward descriptor (start0=0, len0=3, start1=3, len1=1) -> new latch 2 cycles after the pulse, 4 commands, second finish pulse.
5. Wrap and simultaneous events: start0=32'hFFFF_FFFE, len0=4 -> indices FFFF_FFFE, FFFF_FFFF, 0, 1. A response in the same cycle as a transfer keeps the outstanding count unchanged. A spurious rsp_valid_i in IDLE has no effect.
6. Reset mid-block: assert rst_ni low after 3 of 7 commands -> all outputs 0 immediately. After release with type 00, the block stays in IDLE with no finish pulse.

Source files
------------

// File: rtl/intra_layer_block_executor.sv
// Consumer side of the intra-layer block scheduler: latches a two-part block
// descriptor, streams one element command per index and reports block completion.
module intra_layer_block_executor #(
  parameter int ADDR_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] block0_start_i,
  input  logic [ADDR_W-1:0] block0_length_i,
  input  logic [ADDR_W-1:0] block1_start_i,
  input  logic [ADDR_W-1:0] block1_length_i,
  input  logic [1:0]        block_type_i,
  output logic              block_finish_valid_o,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  output logic [ADDR_W-1:0] cmd_index_o,
  output logic              cmd_sel_o,
  output logic [1:0]        cmd_type_o,
  output logic              cmd_last_o,
  input  logic              rsp_valid_i,
  output logic              busy_o
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0]  MAX_OUT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO     = ADDR_W'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE,
    S_HOLD
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  outstanding;
  logic [ADDR_W-1:0] blk1_start;
  logic [ADDR_W-1:0] blk1_length;
  logic [ADDR_W-1:0] remaining;    // elements left in the current sub-block, current one included
  logic              blk_empty;

  logic              xfer;
  logic              rsp_take;
  logic [CNT_W-1:0]  outstanding_nxt;
  logic              can_issue;

  logic [ADDR_W-1:0] first_index;
  logic [ADDR_W-1:0] first_remaining;
  logic              first_sel;
  logic              first_last;
  logic              first_empty;

  logic [ADDR_W-1:0] step_index;
  logic [ADDR_W-1:0] step_remaining;
  logic              step_sel;
  logic              step_last;

  // Valid is registered, so it is computed from the occupancy the counter will
  // hold next cycle; this keeps the in-flight limit exact without a bubble.
  always_comb begin
    xfer            = cmd_valid_o & cmd_ready_i;
    rsp_take        = rsp_valid_i & (outstanding != '0);
    outstanding_nxt = outstanding + CNT_W'(xfer) - CNT_W'(rsp_take);
    can_issue       = outstanding_nxt < MAX_OUT;
  end

  // First element straight from the descriptor inputs, skipping an empty sub-block 0.
  // NOTE: every variable gets a value before any branch so no latch can be inferred.
  always_comb begin
    first_index     = block0_start_i;
    first_remaining = block0_length_i;
    first_sel       = 1'b0;
    first_last      = (block0_length_i == ONE) && (block1_length_i == '0);
    first_empty     = 1'b0;
    if (block0_length_i == '0) begin
      first_index     = block1_start_i;
      first_remaining = block1_length_i;
      first_sel       = 1'b1;
      first_last      = (block1_length_i == ONE);
      first_empty     = (block1_length_i == '0);
    end
  end

  // Element following the one currently presented; index math wraps at 2^ADDR_W.
  always_comb begin
    step_index     = cmd_index_o + ONE;
    step_remaining = remaining - ONE;
    step_sel       = cmd_sel_o;
    step_last      = (remaining == TWO) && (cmd_sel_o || (blk1_length == '0));
    if (!cmd_sel_o && (remaining == ONE)) begin
      step_index     = blk1_start;
      step_remaining = blk1_length;
      step_sel       = 1'b1;
      step_last      = (blk1_length == ONE);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // in this block sees the pre-edge values of the others.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state                <= S_IDLE;
      outstanding          <= '0;
      blk1_start           <= '0;
      blk1_length          <= '0;
      remaining            <= '0;
      blk_empty            <= 1'b0;
      block_finish_valid_o <= 1'b0;
      cmd_valid_o          <= 1'b0;
      cmd_index_o          <= '0;
      cmd_sel_o            <= 1'b0;
      cmd_type_o           <= 2'b00;
      cmd_last_o           <= 1'b0;
      busy_o               <= 1'b0;
    end else begin
      outstanding          <= outstanding_nxt;
      block_finish_valid_o <= 1'b0;

      case (state)
        S_IDLE: begin
          if (block_type_i != 2'b00) begin
            blk1_start  <= block1_start_i;
            blk1_length <= block1_length_i;
            cmd_type_o  <= block_type_i;
            cmd_index_o <= first_index;
            remaining   <= first_remaining;
            cmd_sel_o   <= first_sel;
            cmd_last_o  <= first_last;
            blk_empty   <= first_empty;
            cmd_valid_o <= !first_empty && can_issue;
            busy_o      <= 1'b1;
            state       <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (blk_empty) begin
            block_finish_valid_o <= 1'b1;
            state                <= S_DONE;
          end else if (xfer && cmd_last_o) begin
            cmd_valid_o <= 1'b0;
            state       <= S_DRAIN;
          end else if (xfer) begin
            cmd_index_o <= step_index;
            remaining   <= step_remaining;
            cmd_sel_o   <= step_sel;
            cmd_last_o  <= step_last;
            cmd_valid_o <= can_issue;
          end else begin
            cmd_valid_o <= can_issue;
          end
        end

        S_DRAIN: begin
          if (outstanding == '0) begin
            block_finish_valid_o <= 1'b1;
            state                <= S_DONE;
          end
        end

        S_DONE: begin
          busy_o <= 1'b0;
          state  <= S_HOLD;
        end

        S_HOLD: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intra_layer_block_executor.sv
// Randomized self-checking bench: a queue of expected commands per descriptor
// plus an in-flight count model drive every cycle-level comparison.
module tb_intra_layer_block_executor;

  localparam int ADDR_W  = 32;
  localparam int MAX_OUT = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [ADDR_W-1:0] block0_start_i;
  logic [ADDR_W-1:0] block0_length_i;
  logic [ADDR_W-1:0] block1_start_i;
  logic [ADDR_W-1:0] block1_length_i;
  logic [1:0]        block_type_i;
  logic              block_finish_valid_o;
  logic              cmd_valid_o;
  logic              cmd_ready_i;
  logic [ADDR_W-1:0] cmd_index_o;
  logic              cmd_sel_o;
  logic [1:0]        cmd_type_o;
  logic              cmd_last_o;
  logic              rsp_valid_i;
  logic              busy_o;

  intra_layer_block_executor #(
    .ADDR_W          (ADDR_W),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .block0_start_i       (block0_start_i),
    .block0_length_i      (block0_length_i),
    .block1_start_i       (block1_start_i),
    .block1_length_i      (block1_length_i),
    .block_type_i         (block_type_i),
    .block_finish_valid_o (block_finish_valid_o),
    .cmd_valid_o          (cmd_valid_o),
    .cmd_ready_i          (cmd_ready_i),
    .cmd_index_o          (cmd_index_o),
    .cmd_sel_o            (cmd_sel_o),
    .cmd_type_o           (cmd_type_o),
    .cmd_last_o           (cmd_last_o),
    .rsp_valid_i          (rsp_valid_i),
    .busy_o               (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int earliest_latch = 0;

  typedef struct {
    logic [ADDR_W-1:0] idx;
    logic              sel;
    logic              last;
  } cmd_t;

  // Presents one descriptor and follows the block to its finish pulse.
  // ready_pct < 0 toggles ready every cycle; responses are withheld for rsp_hold cycles.
  task automatic run_block(input logic [ADDR_W-1:0] s0, input logic [ADDR_W-1:0] l0,
                           input logic [ADDR_W-1:0] s1, input logic [ADDR_W-1:0] l1,
                           input logic [1:0] typ, input int ready_pct, input int rsp_pct,
                           input int rsp_hold, input bit chk_lat, input string name);
    cmd_t q[$];
    cmd_t c;
    int   inflight = 0;
    int   latch_cyc;
    int   start;
    int   n;
    int   exp_lat;
    bit   done = 0;
    bit   exp_valid;
    bit   rdy;
    bit   rsp;
    bit   xfer;

    for (int i = 0; i < int'(l0); i++) begin
      c.idx  = s0 + ADDR_W'(i);
      c.sel  = 1'b0;
      c.last = (i == int'(l0) - 1) && (l1 == '0);
      q.push_back(c);
    end
    for (int i = 0; i < int'(l1); i++) begin
      c.idx  = s1 + ADDR_W'(i);
      c.sel  = 1'b1;
      c.last = (i == int'(l1) - 1);
      q.push_back(c);
    end
    n       = q.size();
    exp_lat = (n == 0) ? 2 : n + 3;

    @(negedge clk_i);
    block0_start_i  = s0;
    block0_length_i = l0;
    block1_start_i  = s1;
    block1_length_i = l1;
    block_type_i    = typ;
    start     = cyc;
    latch_cyc = (cyc > earliest_latch) ? cyc : earliest_latch;

    for (int k = 0; k < 3000 && !done; k++) begin
      if (k > 0) @(negedge clk_i);

      checks++;
      if (busy_o !== (cyc > latch_cyc)) begin
        errors++;
        $display("FAIL %s busy cyc=%0d got=%b exp=%b", name, cyc, busy_o, cyc > latch_cyc);
      end

      exp_valid = (cyc > latch_cyc) && (q.size() > 0) && (inflight < MAX_OUT);
      checks++;
      if (cmd_valid_o !== exp_valid) begin
        errors++;
        $display("FAIL %s cmd_valid cyc=%0d got=%b exp=%b inflight=%0d", name, cyc,
                 cmd_valid_o, exp_valid, inflight);
      end

      if (cmd_valid_o === 1'b1 && q.size() > 0) begin
        checks++;
        if ({cmd_index_o, cmd_sel_o, cmd_last_o, cmd_type_o} !==
            {q[0].idx, q[0].sel, q[0].last, typ}) begin
          errors++;
          $display("FAIL %s cmd cyc=%0d got idx=%h sel=%b last=%b type=%b exp idx=%h sel=%b last=%b type=%b",
                   name, cyc, cmd_index_o, cmd_sel_o, cmd_last_o, cmd_type_o,
                   q[0].idx, q[0].sel, q[0].last, typ);
        end
      end

      if (block_finish_valid_o === 1'b1) begin
        checks++;
        if (q.size() != 0 || inflight != 0) begin
          errors++;
          $display("FAIL %s early finish cyc=%0d got pending=%0d inflight=%0d exp 0/0", name,
                   cyc, q.size(), inflight);
        end
        if (chk_lat) begin
          checks++;
          if (cyc - latch_cyc != exp_lat) begin
            errors++;
            $display("FAIL %s finish latency got=%0d exp=%0d", name, cyc - latch_cyc, exp_lat);
          end
        end
        done           = 1;
        earliest_latch = cyc + 2;
        block_type_i   = 2'b00;
      end

      if (ready_pct < 0) rdy = cyc[0];
      else               rdy = ($urandom_range(0, 99) < ready_pct);
      rsp  = (inflight > 0) && (cyc - start >= rsp_hold) && ($urandom_range(0, 99) < rsp_pct);
      cmd_ready_i = rdy;
      rsp_valid_i = rsp;
      xfer = (cmd_valid_o === 1'b1) && rdy;
      if (xfer && q.size() > 0) void'(q.pop_front());
      inflight = inflight + int'(xfer) - int'(rsp);
    end

    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout got no finish pulse exp one", name);
      block_type_i = 2'b00;
    end
  endtask

  // Watches the block-level outputs stay quiet for a number of cycles.
  task automatic expect_idle(input int ncyc, input string name);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk_i);
      checks++;
      if ({busy_o, cmd_valid_o, block_finish_valid_o} !== 3'b000) begin
        errors++;
        $display("FAIL %s idle cyc=%0d got busy/valid/finish=%b%b%b exp 000", name, cyc,
                 busy_o, cmd_valid_o, block_finish_valid_o);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({block_finish_valid_o, cmd_valid_o, cmd_index_o, cmd_sel_o, cmd_type_o,
         cmd_last_o, busy_o} !== '0) begin
      errors++;
      $display("FAIL %s outputs got finish=%b valid=%b idx=%h sel=%b type=%b last=%b busy=%b exp all 0",
               name, block_finish_valid_o, cmd_valid_o, cmd_index_o, cmd_sel_o, cmd_type_o,
               cmd_last_o, busy_o);
    end
  endtask

  task automatic test_reset();
    rst_ni          = 1'b0;
    block0_start_i  = '0;
    block0_length_i = '0;
    block1_start_i  = '0;
    block1_length_i = '0;
    block_type_i    = 2'b00;
    cmd_ready_i     = 1'b0;
    rsp_valid_i     = 1'b0;
    repeat (3) @(negedge clk_i);
    check_all_zero("reset");
    rst_ni         = 1'b1;
    earliest_latch = 0;
    expect_idle(2, "post_reset");
  endtask

  task automatic test_forward();
    run_block(32'd0, 32'd7, 32'd7, 32'd3, 2'b01, 100, 100, 0, 1, "forward");
    expect_idle(3, "forward_after");
  endtask

  task automatic test_backpressure();
    run_block(32'd0, 32'd7, 32'd7, 32'd3, 2'b01, -1, 100, 30, 0, "backpressure");
    run_block(32'd50, 32'd6, 32'd90, 32'd5, 2'b11, 40, 30, 12, 0, "backpressure_rand");
    expect_idle(3, "backpressure_after");
  endtask

  task automatic test_zero_lengths();
    run_block(32'd9, 32'd0, 32'd0, 32'd4, 2'b10, 100, 100, 0, 1, "zero_len0");
    run_block(32'd5, 32'd0, 32'd9, 32'd0, 2'b01, 100, 100, 0, 1, "zero_both");
    run_block(32'd20, 32'd3, 32'd40, 32'd0, 2'b11, 100, 100, 0, 1, "zero_len1");
    expect_idle(3, "zero_after");
  endtask

  task automatic test_back_to_back();
    run_block(32'd0, 32'd7, 32'd7, 32'd3, 2'b01, 100, 100, 0, 1, "b2b_first");
    run_block(32'd0, 32'd3, 32'd3, 32'd1, 2'b10, 100, 100, 0, 1, "b2b_second");
    run_block(32'd8, 32'd0, 32'd0, 32'd0, 2'b11, 100, 100, 0, 1, "b2b_empty");
    run_block(32'd1, 32'd2, 32'd2, 32'd2, 2'b01, 100, 100, 0, 1, "b2b_fourth");
    expect_idle(3, "b2b_after");
  endtask

  task automatic test_wrap_and_spurious();
    @(negedge clk_i);
    rsp_valid_i = 1'b1;
    expect_idle(4, "spurious_rsp");
    rsp_valid_i = 1'b0;
    run_block(32'hFFFF_FFFE, 32'd4, 32'd0, 32'd0, 2'b01, 100, 100, 0, 1, "wrap0");
    run_block(32'h10, 32'd2, 32'hFFFF_FFFD, 32'd5, 2'b11, 100, 50, 0, 0, "wrap1_simul");
    run_block(32'h0, 32'd9, 32'h100, 32'd4, 2'b10, 80, 70, 0, 0, "simul_rand");
    expect_idle(3, "wrap_after");
  endtask

  task automatic test_reset_mid_block();
    int xfers = 0;
    @(negedge clk_i);
    block0_start_i  = 32'd100;
    block0_length_i = 32'd7;
    block1_start_i  = 32'd0;
    block1_length_i = 32'd0;
    block_type_i    = 2'b01;
    cmd_ready_i     = 1'b1;
    rsp_valid_i     = 1'b0;
    for (int k = 0; k < 50 && xfers < 3; k++) begin
      @(negedge clk_i);
      if (cmd_valid_o === 1'b1) xfers++;
    end
    checks++;
    if (xfers != 3) begin
      errors++;
      $display("FAIL abort_setup got transfers=%0d exp 3", xfers);
    end
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check_all_zero("abort_reset");
    @(negedge clk_i);
    block_type_i = 2'b00;
    cmd_ready_i  = 1'b0;
    rst_ni       = 1'b1;
    earliest_latch = 0;
    expect_idle(10, "abort_after");
    run_block(32'd200, 32'd5, 32'd300, 32'd2, 2'b10, 100, 100, 0, 1, "abort_recover");
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] s0, s1, l0, l1;
    logic [1:0]        typ;
    int                rp, sp, hold;
    int                pct[3] = '{100, 70, 30};
    for (int t = 0; t < 14; t++) begin
      s0   = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFF8 + ADDR_W'($urandom_range(0, 7)) : $urandom;
      s1   = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFA + ADDR_W'($urandom_range(0, 5)) : $urandom;
      l0   = ADDR_W'($urandom_range(0, 10));
      l1   = ADDR_W'($urandom_range(0, 10));
      typ  = 2'($urandom_range(1, 3));
      rp   = pct[$urandom_range(0, 2)];
      sp   = pct[$urandom_range(0, 2)];
      hold = ($urandom_range(0, 3) == 0) ? 10 : 0;
      run_block(s0, l0, s1, l1, typ, rp, sp, hold, (rp == 100 && sp == 100 && hold == 0),
                $sformatf("random%0d", t));
      if ($urandom_range(0, 2) == 0) expect_idle(2, "random_gap");
    end
    expect_idle(5, "random_after");
  endtask

  initial begin
    test_reset();
    test_forward();
    test_backpressure();
    test_zero_lengths();
    test_back_to_back();
    test_wrap_and_spurious();
    test_reset_mid_block();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
